// File: rtl/oai211_cell_tester.sv
// Sequential stimulus/checker for an OAI211 library cell: walks all 16 input
// vectors, holds each for SETTLE_CYCLES+1 cycles and compares Y in the last one.
module oai211_cell_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             A,
    output logic             B,
    output logic             C1,
    output logic             C2,
    input  logic             Y,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic             FAIL_VALID,
    output logic [3:0]       FAIL_VEC
);

    localparam int                 HOLD_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         vecIdx;
    logic [HOLD_W-1:0]  holdCnt;

    logic               yExp;
    logic               mismatch;
    logic               sampleNow;
    logic               startAccept;
    logic [ERR_W-1:0]   errNext;

    // The stimulus pins are the vector register itself, so they hold in IDLE.
    assign {A, B, C1, C2} = vecIdx;

    always_comb begin
        yExp        = ~((C1 | C2) & A & B);
        mismatch    = (Y != yExp);
        sampleNow   = (state == RUN) && (holdCnt == HOLD_LAST);
        startAccept = START && (state != RUN);
        errNext     = ERR_COUNT;
        if (sampleNow && mismatch && (ERR_COUNT != '1)) begin
            errNext = ERR_COUNT + 1'b1;
        end
    end

    // NOTE: non-blocking assignments throughout, so every register below sees the pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            vecIdx     <= '0;
            holdCnt    <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_COUNT  <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_VEC   <= '0;
        end else if (startAccept) begin
            state      <= RUN;
            vecIdx     <= '0;
            holdCnt    <= '0;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_COUNT  <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_VEC   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                RUN: begin
                    if (sampleNow) begin
                        ERR_COUNT <= errNext;
                        if (mismatch && !FAIL_VALID) begin
                            FAIL_VALID <= 1'b1;
                            FAIL_VEC   <= vecIdx;
                        end
                        // PASS must account for a mismatch on the final vector too.
                        if (vecIdx == 4'd15) begin
                            state <= FIN;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            PASS  <= (errNext == '0);
                        end else begin
                            vecIdx  <= vecIdx + 1'b1;
                            holdCnt <= '0;
                        end
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oai211_cell_tester.sv
// Self-checking bench for oai211_cell_tester: two instances (default and
// SETTLE_CYCLES=1/ERR_W=4) driven by behavioural cell models on Y.
module tb_oai211_cell_tester;

    typedef enum int {M_IDEAL, M_STUCK1, M_STUCK0, M_INV, M_DELAY, M_MASK} mode_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;

    logic        a1, b1, c11, c21, busy1, done1, pass1, fv1, y1;
    logic [4:0]  err1;
    logic [3:0]  fvec1;
    logic        a2, b2, c12, c22, busy2, done2, pass2, fv2, y2;
    logic [3:0]  err2;
    logic [3:0]  fvec2;

    logic [3:0]  vec1, vec2;
    mode_t       mode = M_IDEAL;
    logic [15:0] faultMask = '0;
    logic        yDly1 = 1'b1;
    logic        yDly2 = 1'b1;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 CLK = ~CLK;

    oai211_cell_tester dut1 (
        .CLK(CLK), .RST(RST), .START(start1),
        .A(a1), .B(b1), .C1(c11), .C2(c21), .Y(y1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_COUNT(err1),
        .FAIL_VALID(fv1), .FAIL_VEC(fvec1)
    );

    oai211_cell_tester #(.SETTLE_CYCLES(1), .ERR_W(4)) dut2 (
        .CLK(CLK), .RST(RST), .START(start2),
        .A(a2), .B(b2), .C1(c12), .C2(c22), .Y(y2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_COUNT(err2),
        .FAIL_VALID(fv2), .FAIL_VEC(fvec2)
    );

    // Ideal OAI211: output is low only when A=B=1 and at least one C is 1,
    // i.e. vector indices 13, 14 and 15.
    function automatic bit refY(input int v);
        return v < 13;
    endfunction

    function automatic bit cellY(input mode_t m, input int v, input logic [15:0] mask);
        case (m)
            M_STUCK1: return 1'b1;
            M_STUCK0: return 1'b0;
            M_INV:    return !refY(v);
            M_MASK:   return refY(v) ^ mask[v];
            default:  return refY(v);
        endcase
    endfunction

    assign vec1 = {a1, b1, c11, c21};
    assign vec2 = {a2, b2, c12, c22};
    assign y1 = (mode == M_DELAY) ? yDly1 : cellY(mode, int'(vec1), faultMask);
    assign y2 = (mode == M_DELAY) ? yDly2 : cellY(mode, int'(vec2), faultMask);

    always @(posedge CLK) begin
        yDly1 <= refY(int'(vec1));
        yDly2 <= refY(int'(vec2));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic setStart(input int d, input logic v);
        if (d == 0) start1 = v;
        else        start2 = v;
    endtask

    // One full run on instance d; expected results come from the cell model
    // compared against the ideal truth table, vector by vector.
    task automatic runTest(input string tag, input int d, input bit noise);
        int          hold   = (d == 0) ? 3 : 2;
        int          lastC  = 16 * hold;
        int          cap    = (d == 0) ? 31 : 15;
        int          nMis   = 0;
        int          first  = -1;
        int          drvMis = 0;
        int          expErr;
        logic [5:0]  obs;
        logic [5:0]  exp;
        logic [3:0]  ev;
        for (int v = 0; v < 16; v++) begin
            if (mode != M_DELAY && cellY(mode, v, faultMask) != refY(v)) begin
                nMis++;
                if (first < 0) first = v;
            end
        end
        expErr = (nMis > cap) ? cap : nMis;

        @(negedge CLK); setStart(d, 1'b1);
        @(negedge CLK); setStart(d, 1'b0);
        for (int c = 0; c <= lastC; c++) begin
            obs = (d == 0) ? {vec1, busy1, done1} : {vec2, busy2, done2};
            ev  = 4'(c / hold);
            exp = (c < lastC) ? {ev, 1'b1, 1'b0} : {4'hF, 1'b0, 1'b1};
            check($sformatf("%s seq c=%0d", tag, c), 32'(obs), 32'(exp));
            if (d == 1 && mode == M_DELAY && c < lastC && (c % hold) == 0
                && yDly2 != refY(int'(vec2))) drvMis++;
            if (noise && c < 47) start1 = 1'($urandom_range(0, 1));
            else if (d == 0)     start1 = 1'b0;
            @(negedge CLK);
        end

        if (d == 0) begin
            check({tag, " pass"}, 32'(pass1), 32'(nMis == 0));
            check({tag, " err"},  32'(err1),  32'(expErr));
            check({tag, " fv"},   32'(fv1),   32'(nMis != 0));
            check({tag, " fvec"}, 32'(fvec1), (first < 0) ? 32'd0 : 32'(first));
        end else begin
            check({tag, " pass"}, 32'(pass2), 32'(nMis == 0));
            check({tag, " err"},  32'(err2),  32'(expErr));
            check({tag, " fv"},   32'(fv2),   32'(nMis != 0));
            check({tag, " fvec"}, 32'(fvec2), (first < 0) ? 32'd0 : 32'(first));
        end
        if (d == 1 && mode == M_DELAY)
            check({tag, " drive-cycle sample sees stale Y"}, 32'(drvMis > 0), 32'd1);

        repeat (5) @(negedge CLK);
        if (d == 0) check({tag, " idle hold"}, {22'd0, pass1, err1, fv1, fvec1},
                          {22'd0, 1'(nMis == 0), 5'(expErr), 1'(nMis != 0),
                           (first < 0) ? 4'd0 : 4'(first)});
        else        check({tag, " idle hold"}, {22'd0, pass2, 1'b0, err2, fv2, fvec2},
                          {22'd0, 1'(nMis == 0), 1'b0, 4'(expErr), 1'(nMis != 0),
                           (first < 0) ? 4'd0 : 4'(first)});
    endtask

    initial begin
        int doneSeen;
        int busySeen;

        // Reset with START held high: reset must win.
        start1 = 1'b1;
        start2 = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset dut1", {vec1, busy1, done1, pass1, err1, fv1, fvec1}, 32'd0);
        check("reset dut2", {vec2, busy2, done2, pass2, err2, fv2, fvec2}, 32'd0);
        start1 = 1'b0;
        start2 = 1'b0;
        RST    = 1'b0;
        @(negedge CLK);

        mode = M_IDEAL;  runTest("ideal",  0, 0);
        mode = M_STUCK1; runTest("stuck1", 0, 0);
        mode = M_STUCK0; runTest("stuck0", 0, 0);
        mode = M_INV;    runTest("inv sat", 1, 0);
        mode = M_DELAY;  runTest("delay s1", 1, 0);
        mode = M_DELAY;  runTest("delay s2", 0, 0);
        for (int k = 0; k < 3; k++) begin
            mode      = M_MASK;
            faultMask = 16'($urandom);
            runTest($sformatf("rand%0d", k), 0, 1);
        end

        // START held high: FIN accepts the restart, so BUSY drops only during DONE.
        mode = M_IDEAL;
        @(negedge CLK); start1 = 1'b1;
        @(negedge CLK);
        for (int c = 0; c <= 97; c++) begin
            check($sformatf("b2b c=%0d", c), {30'd0, busy1, done1},
                  (c == 48 || c == 97) ? 32'd1 : 32'd2);
            if (c == 97) start1 = 1'b0;
            @(negedge CLK);
        end
        repeat (3) @(negedge CLK);

        // Reset in the middle of a failing run discards everything.
        mode = M_STUCK0;
        @(negedge CLK); start1 = 1'b1;
        @(negedge CLK); start1 = 1'b0;
        repeat (20) @(negedge CLK);
        check("midrun err nonzero", 32'(err1 != 0), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrun reset", {vec1, busy1, done1, pass1, err1, fv1, fvec1}, 32'd0);
        RST = 1'b0;
        doneSeen = 0;
        busySeen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (done1) doneSeen++;
            if (busy1) busySeen++;
        end
        check("no done after reset", 32'(doneSeen), 32'd0);
        check("no busy after reset", 32'(busySeen), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
